rr_allocator: RTL and testbench
===============================

# rr_allocator

Round-robin output-port allocator with credit-based flow control for one output of the 4-input butterfly switch. It examines the top four bits of each input phit (type + route field), grants the output to one head phit, and holds it for the packet's payload phits. A downstream credit counter throttles forwarding, and a rotating priority pointer prevents input starvation. One instance sits beside each output port's mux/shifter and drives its select and shift controls.

## Interface
- CREDITS, 4: downstream buffer depth and reset value of the credit counter (1..15).
- CW, 4: credit counter width; must hold CREDITS.
- i_clk  in  1  chip clock; all state updates on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_this_port  in  2  identifies this output port; static.
- i_r0, i_r1, i_r2, i_r3  in  4 each  top four bits of each input phit: [3:2] type, [1:0] route field.
- i_credit  in  1  one-cycle pulse; downstream freed one phit slot.
- o_select  out  4  one-hot (or zero) input-to-output mux select.
- o_ready  out  4  per-input consume strobe; upstream advances its phit only when set.
- o_shift  out  1  directs shifter to discard the upper two route bits; asserted only while a head phit is forwarded.
- o_credits  out  CW  current credit count.
- o_credit_err  out  1  sticky flag; a credit return arrived while the counter was full.

## Operation
- Type decode: 3 = HEAD, 2 = PAYLOAD, 0/1 = idle. request[i] = (type_i == HEAD) && (route_i == i_this_port).
- State: busy (1 b), owner (2 b), ptr (2 b, highest-priority input), credits (CW b), err (1 b).
- avail = !busy || type_owner != PAYLOAD. A packet ends on the first cycle its owner's input is not PAYLOAD.
- Hold: if busy and type_owner == PAYLOAD, o_select = onehot(owner), with no arbitration.
- Arbitration: if avail and credits > 0, grant the first requesting input in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4). o_select = onehot(grant). If there is no request, o_select = 0.
- credits == 0: no new grant. A held owner keeps o_select, but o_ready = 0 (stall).
- Forwarding:
  - o_ready = o_select when credits > 0, else 0.
  - fwd = |o_ready.
  - o_shift = fwd && grant this cycle (head forwarded).
- State update on grant:
  - busy <= 1, owner <= grant index, ptr <= grant index + 1 (mod 4).
  - The grant takes effect only on a cycle where the head is forwarded (credits > 0 is a grant precondition).
- State update when avail with no grant: busy <= 0 (ptr unchanged).
- Credits (next value):
  - fwd && !i_credit: credits - 1.
  - i_credit && !fwd: credits + 1. If credits == CREDITS, hold and set err.
  - both or neither: unchanged.
- Back-to-back packets: a packet tail (owner leaves PAYLOAD) and a new head grant occur in the same cycle with no bubble.
- A new head on the owner's own input is re-arbitrated like any other request.

## Timing
- o_select, o_ready and o_shift are combinational from the inputs and registered state, with zero-cycle latency. The selected phit passes in the same cycle.
- o_credits and o_credit_err are registered outputs.
- State changes on the rising edge following the deciding cycle.
- Reset values: busy = 0, owner = 0, ptr = 0, credits = CREDITS, err = 0. Hence o_select = 0, o_ready = 0, o_shift = 0 while idle inputs are present.
- Reset mid-packet: the allocator returns to idle and the credits refill. Subsequent orphan PAYLOAD phits are never selected.
- i_rst dominates i_credit in the same cycle.
- Stall: upstream holds its phit while o_ready = 0. o_select stays stable across the stall.

## Test plan
- Single head on i_r2 (route = this port), followed by 3 payloads and then idle, with credits full:
  - Required: o_select = 4'b0100 for 4 cycles; o_shift = 1 on cycle 0 only.
  - Required: o_credits = 4,3,2,1,0; ptr ends at 3.
- All four inputs present heads simultaneously, each a 1-phit packet, with i_credit pulsed every cycle:
  - Required: successive grants follow the order r0, r1, r2, r3, r0.
  - Required: grants rotate fairly and no input is granted twice before all others.
- Head on r1 while r0 holds the port with payloads: r1 is ignored until r0's packet ends. r1 is granted on the same cycle r0's input goes idle, with no bubble.
- Credit exhaustion with CREDITS = 2 and a 4-phit packet:
  - Required: o_ready is 1 for 2 cycles, then 0 with o_select held.
  - Required: an i_credit pulse yields one forwarded phit per credit.
- Simultaneous fwd and i_credit: o_credits is unchanged. An i_credit while the counter is full sets o_credit_err, which stays 1 until i_rst.
- i_rst asserted mid-packet: on the next cycle o_select = 0, o_credits = CREDITS and o_credit_err = 0. Trailing PAYLOAD phits receive no grant.

Source files
------------

// File: rtl/rr_allocator.sv
// Round-robin output-port allocator with credit flow control for one switch output.
// select/ready/shift are combinational, with zero latency; a zero credit count stalls the held owner.
module rr_allocator #(
  parameter int CREDITS = 4,
  parameter int CW      = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [1:0]    i_this_port,
  input  logic [3:0]    i_r0,
  input  logic [3:0]    i_r1,
  input  logic [3:0]    i_r2,
  input  logic [3:0]    i_r3,
  input  logic          i_credit,
  output logic [3:0]    o_select,
  output logic [3:0]    o_ready,
  output logic          o_shift,
  output logic [CW-1:0] o_credits,
  output logic          o_credit_err
);

  localparam logic [1:0]    TYPE_HEAD    = 2'd3;
  localparam logic [1:0]    TYPE_PAYLOAD = 2'd2;
  localparam logic [CW-1:0] CREDIT_MAX   = CW'(CREDITS);

  logic          r_busy;
  logic [1:0]    r_owner;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_credits;
  logic          r_err;

  logic [3:0]    w_phit [4];
  logic [1:0]    w_type [4];
  logic [3:0]    w_req;
  logic [7:0]    w_req_dbl;
  logic [3:0]    w_req_rot;
  logic          w_hold;
  logic          w_has_credit;
  logic          w_gnt_vld;
  logic [1:0]    w_gnt_idx;
  logic          w_fwd;
  logic [CW-1:0] w_credits_nxt;
  logic          w_err_set;

  assign w_phit[0] = i_r0;
  assign w_phit[1] = i_r1;
  assign w_phit[2] = i_r2;
  assign w_phit[3] = i_r3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_type[i] = w_phit[i][3:2];
      w_req[i]  = (w_phit[i][3:2] == TYPE_HEAD) && (w_phit[i][1:0] == i_this_port);
    end
  end

  // A packet is held only while its owner keeps presenting payload; anything else ends it.
  assign w_hold       = r_busy && (w_type[r_owner] == TYPE_PAYLOAD);
  assign w_has_credit = (r_credits != '0);

  // Rotate so bit 0 is the current highest-priority input, then take the lowest set bit.
  assign w_req_dbl = {w_req, w_req};
  assign w_req_rot = w_req_dbl[r_ptr +: 4];

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_ptr;
    if (!w_hold && w_has_credit) begin
      for (int j = 3; j >= 0; j--) begin
        if (w_req_rot[j]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = r_ptr + 2'(j);
        end
      end
    end
  end

  always_comb begin
    o_select = 4'b0000;
    if (w_hold) begin
      o_select = 4'b0001 << r_owner;
    end else if (w_gnt_vld) begin
      o_select = 4'b0001 << w_gnt_idx;
    end
  end

  assign o_ready = w_has_credit ? o_select : 4'b0000;
  assign w_fwd   = |o_ready;
  assign o_shift = w_fwd && w_gnt_vld;

  always_comb begin
    w_credits_nxt = r_credits;
    w_err_set     = 1'b0;
    case ({w_fwd, i_credit})
      2'b10: w_credits_nxt = r_credits - CW'(1);
      2'b01: begin
        // A return with no slot outstanding is a protocol error; the count saturates.
        if (r_credits == CREDIT_MAX) begin
          w_err_set = 1'b1;
        end else begin
          w_credits_nxt = r_credits + CW'(1);
        end
      end
      default: w_credits_nxt = r_credits;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy    <= 1'b0;
      r_owner   <= 2'd0;
      r_ptr     <= 2'd0;
      r_credits <= CREDIT_MAX;
      r_err     <= 1'b0;
    end else begin
      if (w_gnt_vld) begin
        r_busy  <= 1'b1;
        r_owner <= w_gnt_idx;
        r_ptr   <= w_gnt_idx + 2'd1;
      end else if (!w_hold) begin
        r_busy <= 1'b0;
      end
      r_credits <= w_credits_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_credits    = r_credits;
  assign o_credit_err = r_err;

endmodule

// File: tb/tb_rr_allocator.sv
// Bench for rr_allocator: two instances (4 and 2 credits) against a queue-free behavioural model.
module tb_rr_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic       credit;
  logic [1:0] tp;
  logic [3:0] r [4];

  logic [3:0] sel_o [2];
  logic [3:0] rdy_o [2];
  logic       sh_o  [2];
  logic [3:0] cr_o  [2];
  logic       er_o  [2];

  int n_cmp = 0;
  int n_bad = 0;

  int m_busy  [2];
  int m_owner [2];
  int m_ptr   [2];
  int m_cred  [2];
  int m_err   [2];
  int m_cmax  [2] = '{4, 2};

  int cap_sel [2];
  int cap_rdy [2];
  int cap_sh  [2];
  int cap_cr  [2];
  int cap_er  [2];

  localparam logic [3:0] H2 = 4'b1110;
  localparam logic [3:0] PL = 4'b1000;
  localparam logic [3:0] ID = 4'b0000;

  always #5 clk = ~clk;

  rr_allocator #(.CREDITS(4), .CW(4)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_this_port(tp),
    .i_r0(r[0]), .i_r1(r[1]), .i_r2(r[2]), .i_r3(r[3]),
    .i_credit(credit),
    .o_select(sel_o[0]), .o_ready(rdy_o[0]), .o_shift(sh_o[0]),
    .o_credits(cr_o[0]), .o_credit_err(er_o[0])
  );

  rr_allocator #(.CREDITS(2), .CW(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_this_port(tp),
    .i_r0(r[0]), .i_r1(r[1]), .i_r2(r[2]), .i_r3(r[3]),
    .i_credit(credit),
    .o_select(sel_o[1]), .o_ready(rdy_o[1]), .o_shift(sh_o[1]),
    .o_credits(cr_o[1]), .o_credit_err(er_o[1])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected combinational outputs straight from the allocation rules.
  task automatic model_out(input int k, output int sel, output int rdy, output int sh, output int gnt);
    int hold;
    gnt  = -1;
    sel  = 0;
    hold = (m_busy[k] != 0 && r[m_owner[k]][3:2] == 2'b10) ? 1 : 0;
    if (hold != 0) begin
      sel = 1 << m_owner[k];
    end else if (m_cred[k] > 0) begin
      for (int j = 0; j < 4; j++) begin
        int idx;
        idx = (m_ptr[k] + j) % 4;
        if (gnt < 0 && r[idx][3:2] == 2'b11 && r[idx][1:0] == tp) gnt = idx;
      end
      if (gnt >= 0) sel = 1 << gnt;
    end
    rdy = (m_cred[k] > 0) ? sel : 0;
    sh  = (rdy != 0 && gnt >= 0) ? 1 : 0;
  endtask

  task automatic step();
    int es [2];
    int er [2];
    int esh [2];
    int eg [2];
    int hold [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_out(k, es[k], er[k], esh[k], eg[k]);
      hold[k]    = (m_busy[k] != 0 && r[m_owner[k]][3:2] == 2'b10) ? 1 : 0;
      cap_sel[k] = int'(sel_o[k]);
      cap_rdy[k] = int'(rdy_o[k]);
      cap_sh[k]  = int'(sh_o[k]);
      cap_cr[k]  = int'(cr_o[k]);
      cap_er[k]  = int'(er_o[k]);
      chk($sformatf("select%0d", k),  cap_sel[k], es[k]);
      chk($sformatf("ready%0d", k),   cap_rdy[k], er[k]);
      chk($sformatf("shift%0d", k),   cap_sh[k],  esh[k]);
      chk($sformatf("credits%0d", k), cap_cr[k],  m_cred[k]);
      chk($sformatf("err%0d", k),     cap_er[k],  m_err[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0;
        m_cred[k] = m_cmax[k]; m_err[k] = 0;
      end else begin
        if (eg[k] >= 0) begin
          m_busy[k] = 1; m_owner[k] = eg[k]; m_ptr[k] = (eg[k] + 1) % 4;
        end else if (hold[k] == 0) begin
          m_busy[k] = 0;
        end
        if (er[k] != 0 && !credit) m_cred[k] = m_cred[k] - 1;
        else if (credit && er[k] == 0) begin
          if (m_cred[k] == m_cmax[k]) m_err[k] = 1;
          else m_cred[k] = m_cred[k] + 1;
        end
      end
    end
    #1;
  endtask

  task automatic drv(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                     input logic [3:0] d, input logic cr);
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    credit = cr;
    rst = 1'b0;
  endtask

  task automatic do_reset(input logic cr);
    drv(ID, ID, ID, ID, cr);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int    t1_sel [5] = '{4, 4, 4, 4, 0};
    int    t1_sh  [5] = '{1, 0, 0, 0, 0};
    int    t1_cr  [5] = '{4, 3, 2, 1, 0};
    logic [3:0] t1_r2 [5] = '{H2, PL, PL, PL, ID};
    int    t2_sel [5] = '{1, 2, 4, 8, 1};
    logic [3:0] t4_r0 [8] = '{H2, PL, PL, PL, PL, PL, PL, ID};
    logic  t4_cr  [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
    int    t4_rdy [8] = '{1, 1, 0, 0, 1, 0, 1, 0};
    int    t4_sel [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int    t4_crd [8] = '{2, 1, 0, 0, 1, 0, 1, 0};

    tp = 2'd2;
    rst = 1'b1; credit = 1'b0;
    for (int i = 0; i < 4; i++) r[i] = ID;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_cred[k] = m_cmax[k]; m_err[k] = 0;
    end
    @(posedge clk); #1;
    do_reset(1'b0);

    // Idle after reset.
    drv(ID, ID, ID, ID, 1'b0);
    step();
    chk("rst_select", cap_sel[0], 0);
    chk("rst_credits", cap_cr[0], 4);

    // Single 4-phit packet on r2.
    for (int c = 0; c < 5; c++) begin
      drv(ID, ID, t1_r2[c], ID, 1'b0);
      step();
      chk("t1_select", cap_sel[0], t1_sel[c]);
      chk("t1_shift", cap_sh[0], t1_sh[c]);
      chk("t1_credits", cap_cr[0], t1_cr[c]);
    end
    drv(ID, ID, ID, ID, 1'b1);
    step();
    drv(H2, H2, H2, H2, 1'b0);
    step();
    chk("t1_ptr_grant", cap_sel[0], 8);

    // Four competing 1-phit packets, credit returned every cycle.
    do_reset(1'b0);
    for (int c = 0; c < 5; c++) begin
      drv(H2, H2, H2, H2, 1'b1);
      step();
      chk("t2_select", cap_sel[0], t2_sel[c]);
      chk("t2_shift", cap_sh[0], 1);
      chk("t2_credits", cap_cr[0], 4);
    end

    // r1 waits for r0's packet, then wins with no bubble.
    do_reset(1'b0);
    drv(H2, H2, ID, ID, 1'b1); step(); chk("t3_c0", cap_sel[0], 1);
    drv(PL, H2, ID, ID, 1'b1); step(); chk("t3_c1", cap_sel[0], 1);
    drv(PL, H2, ID, ID, 1'b1); step(); chk("t3_c2", cap_sel[0], 1);
    drv(ID, H2, ID, ID, 1'b1); step(); chk("t3_c3", cap_sel[0], 2);
    chk("t3_c3_shift", cap_sh[0], 1);
    drv(ID, ID, ID, ID, 1'b0); step(); chk("t3_c4", cap_sel[0], 0);

    // Credit exhaustion on the 2-credit instance.
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      drv(t4_r0[c], ID, ID, ID, t4_cr[c]);
      step();
      chk("t4_ready", cap_rdy[1], t4_rdy[c]);
      chk("t4_select", cap_sel[1], t4_sel[c]);
      chk("t4_credits", cap_cr[1], t4_crd[c]);
    end

    // Credit return while full sets a sticky error.
    do_reset(1'b0);
    drv(ID, ID, ID, ID, 1'b1); step(); chk("t5_err0", cap_er[0], 0);
    for (int c = 0; c < 3; c++) begin
      drv(ID, ID, ID, ID, 1'b0);
      step();
      chk("t5_err_sticky", cap_er[0], 1);
      chk("t5_credits", cap_cr[0], 4);
    end
    do_reset(1'b1);
    drv(ID, ID, ID, ID, 1'b0); step();
    chk("t5_rst_dominates", cap_er[0], 0);

    // Reset in the middle of a packet.
    drv(H2, ID, ID, ID, 1'b0); step(); chk("t6_c0", cap_sel[0], 1);
    drv(PL, ID, ID, ID, 1'b0); step(); chk("t6_c1", cap_sel[0], 1);
    drv(PL, ID, ID, ID, 1'b1); rst = 1'b1; step();
    drv(PL, ID, ID, ID, 1'b0); step();
    chk("t6_select", cap_sel[0], 0);
    chk("t6_credits", cap_cr[0], 4);
    chk("t6_err", cap_er[0], 0);
    drv(PL, ID, ID, ID, 1'b0); step(); chk("t6_orphan", cap_sel[0], 0);

    // Randomized traffic; inputs tend to persist to form long packets and stalls.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          r[i][3:2] = 2'($urandom_range(0, 3));
          r[i][1:0] = ($urandom_range(0, 1) == 0) ? tp : 2'($urandom_range(0, 3));
        end
      end
      credit = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      if (rst) tp = 2'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
